// File: rtl/fir_filter_seq_if.sv
// ---------------------------------------------------------------------------
// fir_filter_seq_if
//   Handshake and coefficient-load bundle for the time-multiplexed FIR filter.
//
//   Parameters
//     DW     signed sample width (input and output)
//     CW     signed coefficient width
//     NTAPS  tap count; sets the coefficient address width
//
//   Signals
//     in_valid / in_ready / in_data     sample stream into the filter
//     out_valid / out_ready / out_data  filtered stream out of the filter
//     coef_we / coef_addr / coef_data   coefficient write port (addr 0 = newest)
//     busy                              filter is in MAC or OUT
//
//   Modports
//     master  the surrounding system (sample source, sink, coefficient loader)
//     slave   the filter itself
// ---------------------------------------------------------------------------
interface fir_filter_seq_if #(
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int NTAPS = 64
);
    localparam int AWD = $clog2(NTAPS);

    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  out_data;

    logic                  coef_we;
    logic [AWD-1:0]        coef_addr;
    logic signed [CW-1:0]  coef_data;

    logic                  busy;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_filter_seq.sv
// ---------------------------------------------------------------------------
// fir_filter_seq
//   Time-multiplexed FIR filter: one multiplier-accumulator walks over NTAPS
//   taps for every accepted sample, then presents a rounded, scaled result on
//   a valid/ready output. Coefficients are loaded at runtime, only while idle.
//
//   Parameters
//     DW     signed sample width                  (default 8)
//     CW     signed coefficient width             (default 16)
//     NTAPS  tap count, 2..256                    (default 64)
//     SHIFT  arithmetic right shift of the sum    (default 24, 0..AW-1)
//
//   Ports
//     clk       clock
//     reset     asynchronous, active-high; clears all state incl. coefficients
//     bus       fir_filter_seq_if.slave: sample in/out handshakes, coefficient
//               write port and busy status
//     sat_flag  sticky clamp indicator (only when FIR_SAT_EN is defined)
//
//   Build option
//     FIR_SAT_EN  when defined, the scaled result is clamped to the DW-bit
//                 signed range and sat_flag records any clamp; otherwise the
//                 result is truncated (wraps) to DW bits.
//
//   Timing: the sample is accepted in IDLE, MAC runs exactly NTAPS cycles,
//   then OUT holds the result until out_ready. One sample per NTAPS+2 cycles
//   with out_ready tied high.
// ---------------------------------------------------------------------------
module fir_filter_seq #(
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int NTAPS = 64,
    parameter int SHIFT = 24
) (
    input  logic             clk,
    input  logic             reset,
    fir_filter_seq_if.slave  bus
`ifdef FIR_SAT_EN
    ,
    output logic             sat_flag
`endif
);
    localparam int AWD = $clog2(NTAPS);
    localparam int PW  = DW + CW;
    localparam int AW  = DW + CW + $clog2(NTAPS);

    // Half-LSB of the shifted result; zero when no shift is applied.
    localparam int                 RSH      = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [AW:0] RND_HALF = (SHIFT > 0) ? ((AW+1)'(1) <<< RSH) : '0;

`ifdef FIR_SAT_EN
    localparam logic signed [AW:0] OMAX = (AW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [AW:0] OMIN = -OMAX - (AW+1)'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_x [NTAPS];
    logic signed [CW-1:0]  r_c [NTAPS];
    logic signed [AW-1:0]  r_acc;
    logic [AWD-1:0]        r_k;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic signed [DW-1:0]  r_out_data;
    logic                  r_busy;
`ifdef FIR_SAT_EN
    logic                  r_sat;
`endif

    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_prod_ext;
    logic signed [AW-1:0]  w_acc_nxt;
    logic signed [AW:0]    w_scaled;
    logic                  w_addr_ok;
    logic                  w_last_tap;

    // Round half up, then arithmetic shift. One guard bit keeps the rounding
    // add from overflowing at the positive extreme of the accumulator.
    function automatic logic signed [AW:0] f_round(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = {a[AW-1], a};
        t = (t + RND_HALF) >>> SHIFT;
        return t;
    endfunction

    // Reduce the scaled value to the output width: clamp or wrap.
    function automatic logic signed [DW-1:0] f_out(input logic signed [AW:0] r);
`ifdef FIR_SAT_EN
        if (r > OMAX)
            return OMAX[DW-1:0];
        else if (r < OMIN)
            return OMIN[DW-1:0];
        else
            return r[DW-1:0];
`else
        return r[DW-1:0];
`endif
    endfunction

`ifdef FIR_SAT_EN
    function automatic logic f_clamps(input logic signed [AW:0] r);
        return (r > OMAX) || (r < OMIN);
    endfunction
`endif

    // Single shared MAC: full signed product, sign-extended into the accumulator.
    assign w_prod     = r_c[r_k] * r_x[r_k];
    assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_acc_nxt  = r_acc + w_prod_ext;
    assign w_scaled   = f_round(w_acc_nxt);
    assign w_last_tap = (r_k == AWD'(NTAPS - 1));

    // Extra address bit so the range test stays meaningful for power-of-two NTAPS.
    assign w_addr_ok  = ({1'b0, bus.coef_addr} < (AWD+1)'(NTAPS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
`ifdef FIR_SAT_EN
            r_sat       <= 1'b0;
`endif
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Also raises in_ready in the first cycle after reset.
                    r_in_ready <= 1'b1;

                    // Coefficients only change between passes; a write in the
                    // accept cycle is already visible to the first MAC cycle.
                    if (bus.coef_we && w_addr_ok)
                        r_c[bus.coef_addr] <= bus.coef_data;

                    if (bus.in_valid && r_in_ready) begin
                        r_x[0] <= bus.in_data;
                        for (int i = 1; i < NTAPS; i++)
                            r_x[i] <= r_x[i-1];
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_MAC;
                    end
                end

                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + AWD'(1);
                    // Result is formed from the final sum directly so that
                    // out_valid rises in the cycle right after the last tap.
                    if (w_last_tap) begin
                        r_out_data  <= f_out(w_scaled);
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
`ifdef FIR_SAT_EN
                        if (f_clamps(w_scaled))
                            r_sat <= 1'b1;
`endif
                    end
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
`ifdef FIR_SAT_EN
    assign sat_flag      = r_sat;
`endif

endmodule

// File: tb/tb_fir_filter_seq.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_seq
//   Directed bench for fir_filter_seq. Two 4-tap instances run in lockstep on
//   identical stimulus: u_dut_a with SHIFT=0 and u_dut_b with SHIFT=2, so each
//   pass checks both the raw and the rounded result. Honours FIR_SAT_EN.
// ---------------------------------------------------------------------------
module tb_fir_filter_seq;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int NTAPS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    fir_filter_seq_if #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) bus_a ();
    fir_filter_seq_if #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) bus_b ();

`ifdef FIR_SAT_EN
    logic sat_a;
    logic sat_b;
`endif

    fir_filter_seq #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(0)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_a)
`ifdef FIR_SAT_EN
        ,
        .sat_flag (sat_a)
`endif
    );

    fir_filter_seq #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_b)
`ifdef FIR_SAT_EN
        ,
        .sat_flag (sat_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic signed [DW-1:0] d);
        bus_a.in_valid = v;
        bus_b.in_valid = v;
        bus_a.in_data  = d;
        bus_b.in_data  = d;
    endtask

    task automatic set_coef(input logic we, input logic [1:0] a,
                            input logic signed [CW-1:0] d);
        bus_a.coef_we   = we;
        bus_b.coef_we   = we;
        bus_a.coef_addr = a;
        bus_b.coef_addr = a;
        bus_a.coef_data = d;
        bus_b.coef_data = d;
    endtask

    task automatic set_ordy(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [CW-1:0] d);
        set_coef(1'b1, a, d);
        tick();
        set_coef(1'b0, 2'd0, '0);
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        write_coef(2'd0, CW'(c0));
        write_coef(2'd1, CW'(c1));
        write_coef(2'd2, CW'(c2));
        write_coef(2'd3, CW'(c3));
    endtask

    // Wait for out_valid; lat counts from the accept cycle (0) to the cycle
    // where out_valid is seen.
    task automatic wait_out(input string tag, input int lat0, input bit lchk);
        int lat;
        lat = lat0;
        while (!bus_a.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (lchk)
            chk({tag, "_lat"}, lat, NTAPS + 1);
        else
            chk({tag, "_ovld"}, bus_a.out_valid, 1);
    endtask

    // Present one sample in IDLE, wait for the result and compare both
    // instances. Leaves the bench one cycle after the output edge, i.e. past
    // the out handshake when out_ready is high.
    task automatic send(input string tag, input logic signed [DW-1:0] s,
                        input bit dchk, input int ea, input int eb);
        set_in(1'b1, s);
        chk({tag, "_rdy"}, bus_a.in_ready, 1);
        tick();
        set_in(1'b0, '0);
        set_coef(1'b0, 2'd0, '0);
        wait_out(tag, 1, 1'b1);
        if (dchk) begin
            chk({tag, "_a"}, bus_a.out_data, ea);
            chk({tag, "_b"}, bus_b.out_data, eb);
        end
        tick();
    endtask

    initial begin
        set_in(1'b0, '0);
        set_coef(1'b0, 2'd0, '0);
        set_ordy(1'b1);

        // Reset state
        tick();
        tick();
        chk("rst_rdy",  bus_a.in_ready,  0);
        chk("rst_ovld", bus_a.out_valid, 0);
        chk("rst_busy", bus_a.busy,      0);
        chk("rst_data", bus_a.out_data,  0);
`ifdef FIR_SAT_EN
        chk("rst_sat",  sat_a,           0);
`endif
        reset = 1'b0;
        tick();
        chk("rel_rdy",  bus_a.in_ready,  1);

        // Impulse: response is the coefficient list
        load4(1, 2, 3, 4);
        send("imp0", 8'sd1, 1'b1, 1, 0);
        send("imp1", 8'sd0, 1'b1, 2, 1);
        send("imp2", 8'sd0, 1'b1, 3, 1);
        send("imp3", 8'sd0, 1'b1, 4, 1);

        // Backpressure: x = {5,0,0,0}; a second sample waits on in_valid
        set_ordy(1'b0);
        send("bp", 8'sd5, 1'b1, 5, 1);
        set_in(1'b1, 8'sd7);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ovld", bus_a.out_valid, 1);
            chk("bp_hold", bus_a.out_data,  5);
            chk("bp_rdy",  bus_a.in_ready,  0);
            chk("bp_busy", bus_a.busy,      1);
            tick();
        end
        set_ordy(1'b1);
        tick();
        chk("bp_idle", bus_a.out_valid, 0);
        // x = {7,5,0,0}: 7*1 + 5*2
        send("bp_next", 8'sd7, 1'b1, 17, 4);

        // Coefficient write in the 2nd MAC cycle is dropped: x = {1,7,5,0}
        set_in(1'b1, 8'sd1);
        chk("cm_rdy", bus_a.in_ready, 1);
        tick();
        set_in(1'b0, '0);
        tick();
        chk("cm_busy", bus_a.busy, 1);
        set_coef(1'b1, 2'd0, 16'sd100);
        tick();
        set_coef(1'b0, 2'd0, '0);
        wait_out("cm", 3, 1'b1);
        chk("cm_a", bus_a.out_data, 30);
        chk("cm_b", bus_b.out_data, 8);
        tick();
        // Next pass still uses c0=1: x = {2,1,7,5} -> 2+2+21+20
        send("cm_keep", 8'sd2, 1'b1, 45, 11);
        // Write and sample in the same IDLE cycle: c0=10, x = {3,2,1,7}
        set_coef(1'b1, 2'd0, 16'sd10);
        send("cm_same", 8'sd3, 1'b1, 65, 16);

        // Rounding with c = {3,0,0,0}
        load4(3, 0, 0, 0);
        send("rnd_pos", 8'sd2,  1'b1, 6, 2);
        send("rnd_neg", -8'sd2, 1'b1, -6, -1);
`ifdef FIR_SAT_EN
        chk("sat_clr", sat_a, 0);
`endif

        // Overflow: sum of 4 * 127 * 127 = 64516
        load4(127, 127, 127, 127);
        send("ovf0", 8'sd127, 1'b0, 0, 0);
        send("ovf1", 8'sd127, 1'b0, 0, 0);
        send("ovf2", 8'sd127, 1'b0, 0, 0);
`ifdef FIR_SAT_EN
        send("ovf3", 8'sd127, 1'b1, 127, 127);
        chk("sat_a", sat_a, 1);
        chk("sat_b", sat_b, 1);
`else
        send("ovf3", 8'sd127, 1'b1, 4, 1);
`endif

        // Reset in the 2nd MAC cycle aborts the pass and clears everything
        load4(1, 2, 3, 4);
        set_in(1'b1, 8'sd9);
        tick();
        set_in(1'b0, '0);
        tick();
        reset = 1'b1;
        #1;
        chk("mr_ovld", bus_a.out_valid, 0);
        chk("mr_data", bus_a.out_data,  0);
        chk("mr_datb", bus_b.out_data,  0);
        chk("mr_busy", bus_a.busy,      0);
        chk("mr_rdy",  bus_a.in_ready,  0);
`ifdef FIR_SAT_EN
        chk("mr_sat",  sat_a,           0);
`endif
        tick();
        tick();
        chk("mr_hold", bus_a.out_valid, 0);
        reset = 1'b0;
        tick();
        chk("mr_rel",  bus_a.in_ready,  1);
        chk("mr_idle", bus_a.busy,      0);

        // Coefficients were cleared: a pass now produces zero
        send("mr_zc", 8'sd5, 1'b1, 0, 0);

        // Fresh reset, reload and repeat the impulse
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load4(1, 2, 3, 4);
        send("rimp0", 8'sd1, 1'b1, 1, 0);
        send("rimp1", 8'sd0, 1'b1, 2, 1);
        send("rimp2", 8'sd0, 1'b1, 3, 1);
        send("rimp3", 8'sd0, 1'b1, 4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
